pwm_fade_ctrl: RTL and testbench
================================

# pwm_fade_ctrl

Sequencer for the bank of PWM channels driving the RGB LED outputs. It owns a free-running period counter, accepts per-channel fade commands over a valid/ready port, and ramps each channel's 14-bit duty width toward its target. Width updates are applied only at PWM period boundaries, so downstream comparators never see a mid-period glitch. Its width outputs feed the `width` inputs of the PWM instances in place of static switch/button wiring.

## Interface
- `CW`, 14: period counter and duty width bits; PWM period is 2^CW cycles.
- `NCH`, 3: number of channels, 1..4.
- `STEP_W`, 4: ramp step bits.

- `clk`  in  1  sole clock; all logic on posedge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command slot empty.
- `cmd_ch`  in  2  target channel index.
- `cmd_target`  in  CW  final duty width.
- `cmd_step`  in  STEP_W  width change per period; 0 means jump to target.
- `width_o`  out  NCH*CW  per-channel duty width; channel k occupies bits [k*CW +: CW].
- `period_tick`  out  1  high in the last cycle of each period.
- `busy`  out  NCH  channel k is ramping.
- `done`  out  NCH  one-cycle pulse when channel k reaches its target.
- `cmd_err`  out  1  one-cycle pulse when an out-of-range channel command is dropped.

## Operation
- Period counter `pcnt` (CW bits) increments every cycle and wraps from 2^CW-1 to 0.
  - `period_tick` = (`pcnt` == 2^CW-1).
  - The register updates below occur on the edge that ends a tick cycle. New widths are therefore first visible at `pcnt`==0.
- Command slot is a single-entry pending register.
  - `cmd_ready` = slot empty.
  - Accept when `cmd_valid` && `cmd_ready`. The slot holds ch/target/step until the next tick edge, then empties.
  - A command accepted in a tick cycle is not applied at that tick's edge. It is applied at the following tick.
  - If `cmd_ch` >= NCH, the command is accepted and discarded. `cmd_err` pulses in the cycle after accept; the slot stays empty.
- Per-channel state is IDLE or RAMP, with registers `w` (current width), `tgt`, and `stp`. At each tick edge:
  - RAMP channels step:
    - If `w` < `tgt`: `w` = min(`w`+`stp`, `tgt`), computed in CW+1 bits.
    - If `w` > `tgt`: `w` = max(`w`-`stp`, `tgt`), with no underflow.
    - On reaching `tgt`, the channel returns to IDLE and pulses `done`.
  - A pending command for channel k overrides k's step at this edge. It loads `tgt` and `stp`; `w` is not stepped this edge.
    - `stp`==0: `w`=`tgt`, IDLE, `done` pulse.
    - `tgt`==`w`: IDLE, `done` pulse.
    - Otherwise: RAMP. The first step happens at the next tick.
  - A retarget during RAMP continues from the current `w` and recomputes direction. The abandoned ramp produces no `done`.
- `busy[k]` = (state[k] == RAMP).
- `done[k]` is high for exactly the cycle after the causing edge, i.e. `pcnt`==0.

## Timing
- Reset (async assert): `pcnt`=0, all `w`=0, all channels IDLE, slot empty.
  - Outputs during and after reset: `width_o`=0, `busy`=0, `done`=0, `cmd_err`=0, `period_tick`=0, `cmd_ready`=1.
  - Reset mid-ramp clears everything immediately, with no clock required.
- Deassertion is taken synchronously to `clk`. The first post-reset cycle has `pcnt`=0.
- Command latency: a command accepted at cycle t takes effect at the first tick edge strictly after t, i.e. 1..2^CW cycles later.
- Back-to-back commands: the second command waits with `cmd_ready`=0 until the cycle after the tick. It can then be accepted, and applies one period later.
- All outputs are registered, except `cmd_ready` and `period_tick`, which are decoded directly from registers.

## Test plan
Bench runs with CW=4 (16-cycle period), NCH=3, STEP_W=4.
1. Reset release:
   - `width_o`=0, `cmd_ready`=1, `busy`=0.
   - `period_tick` first high at cycle 15, then every 16 cycles.
   - Assert `rst_n` low mid-period: all outputs return to reset values at once.
2. Jump: ch0 target 10, step 0, accepted at `pcnt`=3.
   - `cmd_ready`=0 until the tick.
   - Ch0 width becomes 10 at `pcnt`=0.
   - `done[0]` pulses once; `busy[0]` stays 0.
3. Ramp up: ch1 0 to 7, step 3.
   - Ch1 width reads 0, then 3, 6, 7 over successive periods.
   - `busy[1]` is high from load until 7 is reached.
   - `done[1]` pulses with width 7.
4. Ramp down: ch2 first jumped to 15, then target 0 with step 4.
   - Ch2 width reads 11, 7, 3, 0 with no wrap.
   - Concurrent ch1 ramp steps independently in the same periods.
5. Retarget and error handling:
   - Ch1 ramp 0 to 12 step 2, retargeted to 3 after reaching 4: width goes 4 to 3.
   - Exactly one `done[1]` pulse, none for the abandoned target 12.
   - Command with `cmd_ch`=3: `cmd_err` pulses, no width changes.
6. Tick collision: command offered during a tick cycle with the slot empty.
   - Accepted in that cycle, applied one full period later.
   - Command offered while the slot is full at a tick: accepted the cycle after the tick.

Source files
------------

// File: rtl/pwm_fade_ctrl.sv
// PWM fade sequencer: free-running period counter, single-slot fade command port,
// and per-channel duty-width ramps that update only at period boundaries.
module pwm_fade_ctrl #(
    parameter int CW     = 14,
    parameter int NCH    = 3,
    parameter int STEP_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ch,
    input  logic [CW-1:0]       cmd_target,
    input  logic [STEP_W-1:0]   cmd_step,
    output logic [NCH*CW-1:0]   width_o,
    output logic                period_tick,
    output logic [NCH-1:0]      busy,
    output logic [NCH-1:0]      done,
    output logic                cmd_err
);

    typedef enum logic {IDLE, RAMP} ch_state_t;

    localparam logic [2:0] NCH_L = 3'(NCH);

    logic [CW-1:0]     pcnt;
    logic              slot_full;
    logic [1:0]        slot_ch;
    logic [CW-1:0]     slot_tgt;
    logic [STEP_W-1:0] slot_stp;
    logic              err_q;

    ch_state_t         state_q [NCH];
    ch_state_t         state_d [NCH];
    logic [CW-1:0]     w_q     [NCH];
    logic [CW-1:0]     w_d     [NCH];
    logic [CW-1:0]     tgt_q   [NCH];
    logic [CW-1:0]     tgt_d   [NCH];
    logic [STEP_W-1:0] stp_q   [NCH];
    logic [STEP_W-1:0] stp_d   [NCH];
    logic [NCH-1:0]    done_q;
    logic [NCH-1:0]    done_d;

    logic accept;
    logic ch_ok;

    assign period_tick = &pcnt;
    assign cmd_ready   = !slot_full;
    assign accept      = cmd_valid && cmd_ready;
    assign ch_ok       = {1'b0, cmd_ch} < NCH_L;

    // One ramp step toward tgt; the up path is evaluated one bit wider so it cannot wrap.
    function automatic logic [CW-1:0] ramp_step(input logic [CW-1:0] w,
                                                input logic [CW-1:0] tgt,
                                                input logic [STEP_W-1:0] stp);
        logic [CW:0]   sum;
        logic [CW-1:0] stp_x;
        stp_x = CW'(stp);
        sum   = {1'b0, w} + {1'b0, stp_x};
        if (w < tgt)
            ramp_step = (sum > {1'b0, tgt}) ? tgt : sum[CW-1:0];
        else if (w > tgt)
            ramp_step = ((w - tgt) <= stp_x) ? tgt : (w - stp_x);
        else
            ramp_step = w;
    endfunction

    // State register process: counter, command slot, per-channel registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt      <= '0;
            slot_full <= 1'b0;
            slot_ch   <= '0;
            slot_tgt  <= '0;
            slot_stp  <= '0;
            err_q     <= 1'b0;
            done_q    <= '0;
            // NOTE: the per-channel arrays are small flop banks, not RAM, so they are reset here.
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= IDLE;
                w_q[k]     <= '0;
                tgt_q[k]   <= '0;
                stp_q[k]   <= '0;
            end
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            pcnt   <= pcnt + 1'b1;
            err_q  <= accept && !ch_ok;
            done_q <= done_d;
            if (accept && ch_ok) begin
                slot_full <= 1'b1;
                slot_ch   <= cmd_ch;
                slot_tgt  <= cmd_target;
                slot_stp  <= cmd_step;
            end else if (period_tick) begin
                slot_full <= 1'b0;
            end
            for (int k = 0; k < NCH; k++) begin
                state_q[k] <= state_d[k];
                w_q[k]     <= w_d[k];
                tgt_q[k]   <= tgt_d[k];
                stp_q[k]   <= stp_d[k];
            end
        end
    end

    // Next-state process: a pending command for a channel replaces that channel's step.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        done_d = '0;
        for (int k = 0; k < NCH; k++) begin
            state_d[k] = state_q[k];
            w_d[k]     = w_q[k];
            tgt_d[k]   = tgt_q[k];
            stp_d[k]   = stp_q[k];
            if (period_tick) begin
                if (slot_full && slot_ch == 2'(k)) begin
                    tgt_d[k] = slot_tgt;
                    stp_d[k] = slot_stp;
                    if (slot_stp == '0) begin
                        w_d[k]     = slot_tgt;
                        state_d[k] = IDLE;
                        done_d[k]  = 1'b1;
                    end else if (slot_tgt == w_q[k]) begin
                        state_d[k] = IDLE;
                        done_d[k]  = 1'b1;
                    end else begin
                        state_d[k] = RAMP;
                    end
                end else if (state_q[k] == RAMP) begin
                    w_d[k] = ramp_step(w_q[k], tgt_q[k], stp_q[k]);
                    if (ramp_step(w_q[k], tgt_q[k], stp_q[k]) == tgt_q[k]) begin
                        state_d[k] = IDLE;
                        done_d[k]  = 1'b1;
                    end
                end
            end
        end
    end

    // Output process: widths and busy flags straight from the channel registers.
    always_comb begin
        width_o = '0;
        busy    = '0;
        for (int k = 0; k < NCH; k++) begin
            width_o[k*CW +: CW] = w_q[k];
            busy[k]             = (state_q[k] == RAMP);
        end
        done    = done_q;
        cmd_err = err_q;
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl at CW=4/NCH=3/STEP_W=4: a command table feeds a timed
// scoreboard of expected outputs, plus hand-written retarget, tick-collision and reset cases.
module tb_pwm_fade_ctrl;

    localparam int CW = 4, NCH = 3, STEP_W = 4, PER = 16;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_ch;
    logic [CW-1:0]     cmd_target;
    logic [STEP_W-1:0] cmd_step;
    logic [NCH*CW-1:0] width_o;
    logic              period_tick;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done;
    logic              cmd_err;

    pwm_fade_ctrl #(.CW(CW), .NCH(NCH), .STEP_W(STEP_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ch(cmd_ch), .cmd_target(cmd_target), .cmd_step(cmd_step),
        .width_o(width_o), .period_tick(period_tick), .busy(busy), .done(done),
        .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind: 0 width, 1 busy, 2 done, 3 cmd_err, 4 cmd_ready
    typedef struct { int at; int kind; int ch; int val; } exp_t;

    typedef struct packed {
        logic [1:0]      ch;
        logic [3:0]      tgt;
        logic [3:0]      stp;
        logic [3:0]      pc;
        logic [2:0]      n;
        logic            settle;
        logic [4:0][3:0] w;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   tb_pc = 0;
    int   done1_cnt = 0;
    int   cur_w[NCH];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic string kname(input exp_t e);
        case (e.kind)
            0:       return $sformatf("width[%0d]", e.ch);
            1:       return $sformatf("busy[%0d]", e.ch);
            2:       return $sformatf("done[%0d]", e.ch);
            3:       return "cmd_err";
            default: return "cmd_ready";
        endcase
    endfunction

    function automatic int actual(input exp_t e);
        case (e.kind)
            0:       return int'(width_o[e.ch*CW +: CW]);
            1:       return int'(busy[e.ch]);
            2:       return int'(done[e.ch]);
            3:       return int'(cmd_err);
            default: return int'(cmd_ready);
        endcase
    endfunction

    function automatic vec_t mk(input int ch, tgt, stp, pc, n, settle,
                                input int w0, w1, w2, w3, w4);
        vec_t v;
        v.ch = 2'(ch); v.tgt = 4'(tgt); v.stp = 4'(stp); v.pc = 4'(pc);
        v.n = 3'(n); v.settle = 1'(settle);
        v.w[0] = 4'(w0); v.w[1] = 4'(w1); v.w[2] = 4'(w2); v.w[3] = 4'(w3); v.w[4] = 4'(w4);
        return v;
    endfunction

    function automatic int visible_at(input int t);
        return ((t + 1) / PER + 1) * PER;
    endfunction

    task automatic push(input int at, input int kind, input int ch, input int val);
        exp_t e;
        e.at = at; e.kind = kind; e.ch = ch; e.val = val;
        sb.push_back(e);
    endtask

    // Advance one clock; sample 1 ns after the edge and retire due scoreboard entries.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tb_pc = (tb_pc + 1) % PER;
        check("period_tick", int'(period_tick), int'(tb_pc == PER - 1));
        if (done[1]) done1_cnt++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                check(kname(sb[i]), actual(sb[i]), sb[i].val);
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                check({"missed_", kname(sb[i])}, -1, sb[i].val);
                sb.delete(i);
            end
        end
    endtask

    task automatic wait_pc(input int pc);
        for (int i = 0; i < 2 * PER && tb_pc != pc; i++) step();
        if (tb_pc != pc) timeout("wait_pc");
    endtask

    task automatic wait_cyc(input int c);
        for (int i = 0; i < 400 && cyc < c; i++) step();
        if (cyc != c) timeout("wait_cyc");
    endtask

    task automatic settle();
        for (int i = 0; i < 600 && sb.size() != 0; i++) step();
        if (sb.size() != 0) timeout("settle");
    endtask

    // Drive a command in the current cycle once the slot is free; t is the accept cycle.
    task automatic send(input int ch, input int tgt, input int stp, output int t);
        for (int i = 0; i < 3 * PER && !cmd_ready; i++) step();
        if (!cmd_ready) timeout("cmd_ready");
        cmd_valid  = 1'b1;
        cmd_ch     = 2'(ch);
        cmd_target = 4'(tgt);
        cmd_step   = 4'(stp);
        t = cyc;
    endtask

    task automatic finish_send();
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_width"}, int'(width_o), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_cmd_err"}, int'(cmd_err), 0);
        check({tag, "_tick"}, int'(period_tick), 0);
        check({tag, "_ready"}, int'(cmd_ready), 1);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        tb_pc = 0;
        check_reset_outputs("post_reset");
    endtask

    initial begin
        int t, vis, vis2, tb;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_target = '0; cmd_step = '0;
        for (int c = 0; c < NCH; c++) cur_w[c] = 0;

        vecs[0] = mk(0, 10, 0, 3, 1, 1, 10, 0, 0, 0, 0);   // jump
        vecs[1] = mk(1, 7, 3, 2, 4, 1, 0, 3, 6, 7, 0);     // ramp up with clamp
        vecs[2] = mk(2, 15, 0, 5, 1, 1, 15, 0, 0, 0, 0);   // jump to top
        vecs[3] = mk(2, 0, 4, 5, 5, 1, 15, 11, 7, 3, 0);   // ramp down, no wrap
        vecs[4] = mk(1, 15, 2, 5, 5, 0, 7, 9, 11, 13, 15); // concurrent with ch2
        vecs[5] = mk(3, 9, 1, 7, 0, 1, 0, 0, 0, 0, 0);     // out-of-range channel
        vecs[6] = mk(0, 10, 5, 4, 1, 1, 10, 0, 0, 0, 0);   // target equals width
        vecs[7] = mk(0, 15, 4, 6, 3, 1, 10, 14, 15, 0, 0); // clamp at full scale

        #2;
        check_reset_outputs("in_reset");
        release_reset();

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].settle) settle();
            wait_pc(int'(vecs[v].pc));
            send(int'(vecs[v].ch), int'(vecs[v].tgt), int'(vecs[v].stp), t);
            vis = visible_at(t);
            if (int'(vecs[v].ch) >= NCH) begin
                push(t + 1, 3, 0, 1);
                push(t + 2, 3, 0, 0);
                push(t + 1, 4, 0, 1);
                for (int c = 0; c < NCH; c++) push(vis, 0, c, cur_w[c]);
            end else begin
                push(t + 1, 4, 0, 0);
                push(vis - 1, 4, 0, 0);
                push(vis, 4, 0, 1);
                for (int i = 0; i < int'(vecs[v].n); i++) begin
                    push(vis + PER * i, 0, int'(vecs[v].ch), int'(vecs[v].w[i]));
                    push(vis + PER * i, 1, int'(vecs[v].ch), int'(i < int'(vecs[v].n) - 1));
                    push(vis + PER * i, 2, int'(vecs[v].ch), int'(i == int'(vecs[v].n) - 1));
                end
                push(vis + PER * (int'(vecs[v].n) - 1) + 1, 2, int'(vecs[v].ch), 0);
                cur_w[vecs[v].ch] = int'(vecs[v].w[int'(vecs[v].n) - 1]);
            end
            finish_send();
        end

        // Retarget: ch1 0->12 step 2, redirected to 3 once it reads 4.
        settle();
        wait_pc(2);
        send(1, 0, 0, t);
        vis = visible_at(t);
        push(vis, 0, 1, 0);
        push(vis, 2, 1, 1);
        finish_send();
        settle();
        done1_cnt = 0;
        wait_pc(2);
        send(1, 12, 2, t);
        vis = visible_at(t);
        push(vis, 0, 1, 0);
        push(vis, 1, 1, 1);
        push(vis + PER, 0, 1, 2);
        push(vis + 2 * PER, 0, 1, 4);
        push(vis + 2 * PER, 1, 1, 1);
        finish_send();
        wait_cyc(vis + 2 * PER + 2);
        send(1, 3, 2, t);
        vis2 = visible_at(t);
        push(vis2, 0, 1, 4);
        push(vis2, 1, 1, 1);
        push(vis2, 2, 1, 0);
        push(vis2 + PER, 0, 1, 3);
        push(vis2 + PER, 1, 1, 0);
        push(vis2 + PER, 2, 1, 1);
        finish_send();
        settle();
        check("done1_count", done1_cnt, 1);

        // Command offered in a tick cycle with the slot empty: applies a full period later.
        settle();
        wait_pc(PER - 1);
        send(0, 3, 0, t);
        vis = visible_at(t);
        check("tick_accept_latency", vis - t, PER + 1);
        push(t + 1, 4, 0, 0);
        push(t + 1, 0, 0, 15);
        push(vis - 1, 0, 0, 15);
        push(vis, 0, 0, 3);
        push(vis, 2, 0, 1);
        push(vis, 4, 0, 1);
        finish_send();
        settle();

        // Second command held while the slot is full: accepted the cycle after the tick.
        wait_pc(10);
        send(2, 5, 0, t);
        push(t + 1, 4, 0, 0);
        finish_send();
        cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_target = 4'd8; cmd_step = 4'd0;
        for (int i = 0; i < 2 * PER && !cmd_ready; i++) step();
        if (!cmd_ready) timeout("held_cmd_ready");
        tb = cyc;
        check("held_accept_pc", tb_pc, 0);
        check("held_width2_now", int'(width_o[2*CW +: CW]), 5);
        check("held_width0_now", int'(width_o[0 +: CW]), 3);
        vis = visible_at(tb);
        push(tb + 1, 4, 0, 0);
        push(vis, 0, 0, 8);
        push(vis, 2, 0, 1);
        finish_send();
        settle();

        // Asynchronous reset in the middle of a ramp.
        send(2, 15, 1, t);
        finish_send();
        repeat (20) step();
        check("ramp_busy2", int'(busy[2]), 1);
        wait_pc(7);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        sb.delete();
        release_reset();
        repeat (PER) step();

        if (sb.size() != 0) timeout("scoreboard_leftover");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
